quiz_countdown_ctrl: RTL
========================

Name: quiz_countdown_ctrl

Overview:
Controller for a multi-contestant quiz buzzer. It owns and sequences a one-digit BCD countdown timer and arbitrates contestant buzz inputs. It runs a prescaled one-second countdown from a preset digit, captures the first valid responder, flags early (foul) presses, and raises an alarm on timeout. Its outputs drive the seven-segment display and LED logic on the 50 MHz board.

Parameters:
N, 4, number of contestants (2..8)
WID, 2, width of winner index; 2**WID >= N
TICK_DIV, 50_000_000, clk cycles per countdown tick (1 s at 50 MHz); >= 2
START_VAL, 9, countdown preset digit, 0..9

Ports:
clk  input  1  system clock; all registers update on the falling edge
reset  input  1  reset, synchronous, active-high
start  input  1  host start level; only its rising edge acts
clear  input  1  host clear level; returns the block to IDLE
buzz  input  N  contestant buttons, active-high levels, pre-debounced
bcd  output  4  current countdown digit, BCD 8421
winner  output  WID  index of the captured responder
winner_valid  output  1  high while winner holds a valid index
foul  output  N  latched mask of contestants who pressed before start
alarm  output  1  high in TIMEOUT
state  output  2  IDLE=0, RUN=1, ANSWERED=2, TIMEOUT=3

Behaviour:
- Reset values: state=IDLE, bcd=START_VAL, winner=0, winner_valid=0, foul=0, alarm=0, prescaler=0, start_q=0.
- Start detection: start_q registers start every cycle. start_rise = start & ~start_q.
- Prescaler: counts 0..TICK_DIV-1 only in RUN. It is forced to 0 in every other state and on entry to RUN. tick = RUN & (prescaler==TICK_DIV-1); the prescaler wraps to 0 on tick.
- Priority each cycle: reset > clear > state logic.
- clear (any state): next state IDLE, bcd=START_VAL, winner_valid=0, winner=0, foul=0, alarm=0.
- IDLE:
  - bcd holds START_VAL.
  - Any buzz[i]=1 sets foul[i]. Foul bits are sticky until clear or reset.
  - start_rise: go to RUN and clear the prescaler. Buzzes in the same cycle still set foul.
- RUN:
  - eligible = buzz & ~foul.
  - If eligible != 0: go to ANSWERED. winner = lowest set index of eligible (fixed priority, index 0 highest). winner_valid=1. bcd frozen at its current value.
  - Else on tick: if bcd==0, go to TIMEOUT with alarm=1 and bcd=0; otherwise bcd = bcd-1.
  - Buzz and tick in the same cycle: the buzz wins and bcd is not decremented. This applies also when bcd==0.
  - start_rise is ignored.
  - A buzz from a fouled contestant never wins, even if it is the only press.
- ANSWERED: all outputs hold. buzz and start are ignored. Leave only via clear.
- TIMEOUT: alarm=1, bcd=0, winner_valid=0. buzz and start are ignored. Leave only via clear.
- Timing: let E0 be the edge that enters RUN.
  - First decrement at E0+TICK_DIV.
  - bcd reaches 0 at E0+START_VAL*TICK_DIV.
  - TIMEOUT is entered at E0+(START_VAL+1)*TICK_DIV.
  - Buzz capture latency is 1 edge: the winner is visible after the edge on which buzz is sampled high.
- All outputs are registered; no combinational input-to-output paths.
- bcd never leaves 0..9. No wrap from 0 to 9 in this block.
- reset asserted mid-RUN or mid-ANSWERED gives the full reset values on the next edge.

Test Plan:
1. Timeout sequence (TICK_DIV=4, START_VAL=9): reset, then start pulse, no buzz -> bcd steps 9,8,...,0 every 4 cycles; state=TIMEOUT and alarm=1 exactly 40 edges after the start edge; clear returns to IDLE with bcd=9 and alarm=0.
2. Simultaneous buzz arbitration: start, wait until bcd=6, then buzz=4'b1010 -> winner=1, winner_valid=1, state=ANSWERED, bcd frozen at 6; later buzz=4'b0001 and further ticks cause no change.
3. Foul lockout: in IDLE press buzz[0], release, then start; in RUN press buzz[0] only -> foul=4'b0001 and state stays RUN; then press buzz[2] -> winner=2.
4. Buzz coincident with tick at bcd=0 -> ANSWERED, winner valid, bcd=0, alarm=0 (no TIMEOUT).
5. Start held high across clear: start high continuously with clear pulsed in RUN -> IDLE, and no re-entry to RUN until start falls and rises again; clear and start_rise in the same cycle -> IDLE.
6. Reset mid-RUN at bcd=3 -> next edge: state=IDLE, bcd=9, foul=0, winner_valid=0, prescaler restarts from 0 on the next start.

Source files
------------

// File: rtl/quiz_countdown_ctrl_if.sv
// Host/display-side signal bundle for the quiz buzzer countdown controller.
// The controller uses the slave modport; the host or bench uses master.
interface quiz_countdown_ctrl_if #(
  parameter int N   = 4,
  parameter int WID = 2
);
  logic           start;
  logic           clear;
  logic [N-1:0]   buzz;
  logic [3:0]     bcd;
  logic [WID-1:0] winner;
  logic           winner_valid;
  logic [N-1:0]   foul;
  logic           alarm;
  logic [1:0]     state;

  modport master (
    output start, clear, buzz,
    input  bcd, winner, winner_valid, foul, alarm, state
  );

  modport slave (
    input  start, clear, buzz,
    output bcd, winner, winner_valid, foul, alarm, state
  );
endinterface

// File: rtl/quiz_countdown_ctrl.sv
// Quiz buzzer controller: prescaled one-digit BCD countdown, first-responder
// capture with fixed priority, sticky foul mask for early presses, timeout alarm.
module quiz_countdown_ctrl #(
  parameter int N         = 4,
  parameter int WID       = 2,
  parameter int TICK_DIV  = 50_000_000,
  parameter int START_VAL = 9
) (
  input  logic               clk,
  input  logic               reset,
  quiz_countdown_ctrl_if.slave bus
);

  localparam int            PW         = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [3:0]    BCD_PRESET = 4'(START_VAL);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_ANSWERED = 2'd2,
    ST_TIMEOUT  = 2'd3
  } state_t;

  state_t         state_r;
  state_t         state_nxt_s;
  logic           start_q_r;
  logic           start_rise_s;
  logic [PW-1:0]  presc_r;
  logic [PW-1:0]  presc_nxt_s;
  logic           tick_s;
  logic [N-1:0]   eligible_s;
  logic [3:0]     bcd_r;
  logic [3:0]     bcd_nxt_s;
  logic [WID-1:0] winner_r;
  logic [WID-1:0] winner_nxt_s;
  logic           winner_valid_r;
  logic           winner_valid_nxt_s;
  logic [N-1:0]   foul_r;
  logic [N-1:0]   foul_nxt_s;
  logic           alarm_r;
  logic           alarm_nxt_s;

  // Lowest set index wins; scanning downward leaves the smallest index last.
  function automatic logic [WID-1:0] first_set(input logic [N-1:0] v);
    logic [WID-1:0] idx;
    idx = {WID{1'b0}};
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = WID'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  assign start_rise_s = bus.start & ~start_q_r;
  assign tick_s       = (state_r == ST_RUN) && (presc_r == PRESC_LAST);
  assign eligible_s   = bus.buzz & ~foul_r;

  // State register; the board logic updates on the falling clock edge.
  always_ff @(negedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode; clear overrides every state.
  always_comb begin
    state_nxt_s = state_r;
    if (bus.clear) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_rise_s) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_RUN: begin
          // A valid buzz beats a coincident tick, including the final one.
          if (eligible_s != {N{1'b0}}) begin
            state_nxt_s = ST_ANSWERED;
          end else if (tick_s && (bcd_r == 4'd0)) begin
            state_nxt_s = ST_TIMEOUT;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_ANSWERED: state_nxt_s = ST_ANSWERED;
        ST_TIMEOUT:  state_nxt_s = ST_TIMEOUT;
        default:     state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Next values of the datapath and of every registered output.
  always_comb begin
    presc_nxt_s        = {PW{1'b0}};
    bcd_nxt_s          = bcd_r;
    winner_nxt_s       = winner_r;
    winner_valid_nxt_s = winner_valid_r;
    foul_nxt_s         = foul_r;
    alarm_nxt_s        = alarm_r;
    if (bus.clear) begin
      bcd_nxt_s          = BCD_PRESET;
      winner_nxt_s       = {WID{1'b0}};
      winner_valid_nxt_s = 1'b0;
      foul_nxt_s         = {N{1'b0}};
      alarm_nxt_s        = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          bcd_nxt_s  = BCD_PRESET;
          foul_nxt_s = foul_r | bus.buzz;
        end
        ST_RUN: begin
          if (eligible_s != {N{1'b0}}) begin
            winner_nxt_s       = first_set(eligible_s);
            winner_valid_nxt_s = 1'b1;
          end else if (tick_s) begin
            if (bcd_r == 4'd0) begin
              alarm_nxt_s = 1'b1;
              bcd_nxt_s   = 4'd0;
            end else begin
              bcd_nxt_s = bcd_r - 4'd1;
            end
          end else begin
            presc_nxt_s = presc_r + {{(PW-1){1'b0}}, 1'b1};
          end
        end
        ST_ANSWERED: begin
          bcd_nxt_s = bcd_r;
        end
        ST_TIMEOUT: begin
          alarm_nxt_s        = 1'b1;
          bcd_nxt_s          = 4'd0;
          winner_valid_nxt_s = 1'b0;
        end
        default: begin
          bcd_nxt_s = BCD_PRESET;
        end
      endcase
    end
  end

  // Datapath and output registers, including the start edge detector.
  always_ff @(negedge clk) begin
    if (reset) begin
      start_q_r      <= 1'b0;
      presc_r        <= {PW{1'b0}};
      bcd_r          <= BCD_PRESET;
      winner_r       <= {WID{1'b0}};
      winner_valid_r <= 1'b0;
      foul_r         <= {N{1'b0}};
      alarm_r        <= 1'b0;
    end else begin
      start_q_r      <= bus.start;
      presc_r        <= presc_nxt_s;
      bcd_r          <= bcd_nxt_s;
      winner_r       <= winner_nxt_s;
      winner_valid_r <= winner_valid_nxt_s;
      foul_r         <= foul_nxt_s;
      alarm_r        <= alarm_nxt_s;
    end
  end

  assign bus.state        = state_r;
  assign bus.bcd          = bcd_r;
  assign bus.winner       = winner_r;
  assign bus.winner_valid = winner_valid_r;
  assign bus.foul         = foul_r;
  assign bus.alarm        = alarm_r;

endmodule
